// File: rtl/stream_serializer.sv
// Wide-to-narrow stream width converter: one NUM_BEATS*DATA_WIDTH word in,
// NUM_BEATS DATA_WIDTH beats out, with last_out marking the final beat.
module stream_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BEATS  = 4,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_BEATS*DATA_WIDTH-1:0] data_in,
  input  logic                            valid_in,
  output logic                            ready_in,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            valid_out,
  output logic                            last_out,
  input  logic                            ready_out
);

  localparam int CW = (NUM_BEATS < 2) ? 1 : $clog2(NUM_BEATS);
  localparam logic [CW-1:0] LAST = CW'(NUM_BEATS - 1);

  generate
    if (NUM_BEATS < 2) begin : g_bad_beats
      $error("stream_serializer: NUM_BEATS must be 2 or more");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                state, state_nxt;
  logic [NUM_BEATS-1:0][DATA_WIDTH-1:0]  word_reg, word_nxt;
  logic [CW-1:0]                         beat_cnt, cnt_nxt, idx;
  logic                                  insert, remove;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      word_reg <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= cnt_nxt;
      word_reg <= word_nxt;
    end
  end

  // Outputs decode from registered state only, so valid_out never sees valid_in.
  always_comb begin
    valid_out = (state == SEND);
    last_out  = valid_out && (beat_cnt == LAST);
    ready_in  = (state == IDLE) || (last_out && ready_out);
    insert    = valid_in && ready_in;
    remove    = valid_out && ready_out;
    idx       = MSB_FIRST ? (LAST - beat_cnt) : beat_cnt;
    data_out  = valid_out ? word_reg[idx] : '0;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    word_nxt  = word_reg;
    case (state)
      IDLE: begin
        if (insert) begin
          word_nxt  = data_in;
          cnt_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (remove) begin
          if (!last_out) begin
            cnt_nxt = beat_cnt + 1'b1;
          end else if (insert) begin
            // back-to-back: reload without dropping to IDLE, no bubble
            word_nxt = data_in;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/stream_serializer.md
Name: stream_serializer

Overview:
- Transmit-side width converter for the valid/ready streaming fabric.
- Accepts one wide word of NUM_BEATS*DATA_WIDTH bits per input handshake and emits it as NUM_BEATS narrow beats on a valid/ready output.
- Flags the final beat with last_out, so a downstream receiver/deserializer can re-frame the stream.
- Sits between wide compute outputs and narrow transport links. Full throughput: one beat per cycle, with no bubble between consecutive words.

Parameters:
- DATA_WIDTH, 8, width of one output beat in bits.
- NUM_BEATS, 4, beats per input word. Legal range is 2 or more; elaboration error if it is less than 2.
- MSB_FIRST, 0, 0 = emit the least-significant slice first; 1 = emit the most-significant slice first.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  NUM_BEATS*DATA_WIDTH  wide input word.
- valid_in  input  1  input word valid.
- ready_in  output  1  block can accept a word this cycle.
- data_out  output  DATA_WIDTH  current beat.
- valid_out  output  1  data_out holds a valid beat.
- last_out  output  1  current beat is the final beat of its word.
- ready_out  input  1  downstream accepts the beat.

Behaviour:
- Handshake definitions:
  - insert = valid_in & ready_in.
  - remove = valid_out & ready_out.
- Interface rules:
  - Once valid_out is asserted, it stays high and data_out/last_out stay stable until remove.
  - valid_out never depends combinationally on valid_in.
- State:
  - shift/hold register word_reg (NUM_BEATS*DATA_WIDTH bits).
  - beat counter beat_cnt, width $clog2(NUM_BEATS).
  - FSM with states IDLE and SEND.
- IDLE:
  - valid_out = 0 and ready_in = 1.
  - On insert: word_reg <= data_in, beat_cnt <= 0, go to SEND.
  - First beat is visible the next cycle (latency 1 cycle, input handshake to valid_out).
- SEND:
  - valid_out = 1.
  - data_out = slice beat_cnt of word_reg. With MSB_FIRST = 1, the index is NUM_BEATS-1-beat_cnt.
  - last_out = (beat_cnt == NUM_BEATS-1).
  - remove with last_out = 0: beat_cnt <= beat_cnt + 1.
  - remove with last_out = 1 and insert in the same cycle (back-to-back):
    - load the new word and reset beat_cnt to 0.
    - remain in SEND; beat 0 of the new word appears the next cycle with no bubble.
  - remove with last_out = 1 and no insert: go to IDLE, beat_cnt <= 0.
  - No remove: hold everything.
- ready_in is combinational: ready_in = (state == IDLE) | (last_out & ready_out).
  - This is a direct ready_out -> ready_in path. Integrators place a skid_buffer upstream where timing requires.
- Counter range: beat_cnt never exceeds NUM_BEATS-1. Non-power-of-two NUM_BEATS (e.g. 3) must work.
- Reset values (rst high at a clock edge, including mid-word):
  - state = IDLE, beat_cnt = 0, word_reg = 0.
  - valid_out = 0, last_out = 0, data_out = 0.
  - ready_in = 1 in the first cycle after reset.
  - A partially sent word is discarded; no further beats of it are emitted.
- An input offered while not ready_in is not accepted. It must be held by the source under the standard valid/ready rule.
- Throughput: NUM_BEATS output beats per input word, sustained with no idle cycles.

Test Plan:
- Reset then a single word: DATA_WIDTH = 8, NUM_BEATS = 4, MSB_FIRST = 0, ready_out = 1, insert 0x44332211.
  - Required: beats 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles, starting 1 cycle after the insert.
  - Required: last_out high only with 0x44, then valid_out = 0.
- MSB_FIRST = 1, same word.
  - Required: beats 0x44, 0x33, 0x22, 0x11, with last_out on 0x11.
- Back-to-back: valid_in held high with words 0xA3A2A1A0 then 0xB3B2B1B0, ready_out = 1.
  - Required: 8 consecutive beats A0..A3, B0..B3 with no bubble.
  - Required: ready_in high exactly in the cycle A3 is removed.
- Backpressure: during word 0x44332211, drop ready_out for 3 cycles while beat 0x22 is presented.
  - Required: 0x22 holds stable with valid_out = 1 and ready_in = 0.
  - Required: sequence resumes 0x22, 0x33, 0x44 after release, with no loss or duplication.
- Reset mid-word: assert rst after beat 0x22 is removed.
  - Required: next cycle valid_out = 0, data_out = 0, ready_in = 1.
  - Required: a new word 0x0D0C0B0A then emits 0x0A first.
- NUM_BEATS = 3, DATA_WIDTH = 4, with random valid_in/ready_out stalls over 1000 words.
  - Required: the scoreboard-reassembled words match the inputs, and last_out occurs every 3rd beat.
